mem_wb: RTL and testbench

MEM_WB -- requirements
Module: mem_wb

---
 rtl/mem_wb_pkg.sv | 24 ++
 rtl/mem_wb_load_ext.sv | 41 ++++
 rtl/mem_wb.sv | 96 +++++++++
 tb/tb_mem_wb.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pkg.sv
// Shared definitions for the MEM/WB pipeline stage: bus widths, load data-type codes
// and writeback FSM state encodings.
package mem_wb_pkg;

  localparam int unsigned Xlen         = 32;
  localparam int unsigned RegAddrWidth = 5;
  localparam int unsigned CsrAddrWidth = 12;
  localparam int unsigned DataTypeW    = 3;

  // Load width/sign codes; any other value behaves as a full-word load
  typedef enum logic [DataTypeW-1:0] {
    DtLb  = 3'd0,
    DtLh  = 3'd1,
    DtLw  = 3'd2,
    DtLbu = 3'd4,
    DtLhu = 3'd5
  } data_type_e;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StWait = 1'b1
  } wb_state_e;

endpackage

// File: rtl/mem_wb_load_ext.sv
// load_ext: combinational load-data alignment and sign/zero extension.
// Build option: MEM_WB_SUBWORD_EN enables sub-word selection; without it the raw word
// passes through and the type/offset inputs are ignored.
module load_ext
  import mem_wb_pkg::*;
(
  input  logic [DataTypeW-1:0] data_type_i,
  input  logic [1:0]           addr_lo_i,
  input  logic [Xlen-1:0]      raw_i,
  output logic [Xlen-1:0]      data_o
);

`ifdef MEM_WB_SUBWORD_EN
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/halfword, then extend according to the load type
  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = raw_i[7:0];
      2'd1:    byte_sel = raw_i[15:8];
      2'd2:    byte_sel = raw_i[23:16];
      default: byte_sel = raw_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? raw_i[31:16] : raw_i[15:0];
    case (data_type_i)
      DtLb:    data_o = {{24{byte_sel[7]}}, byte_sel};
      DtLbu:   data_o = {24'h0, byte_sel};
      DtLh:    data_o = {{16{half_sel[15]}}, half_sel};
      DtLhu:   data_o = {16'h0, half_sel};
      default: data_o = raw_i;
    endcase
  end
`else
  logic unused_sel;

  assign unused_sel = ^{data_type_i, addr_lo_i};
  assign data_o     = raw_i;
`endif

endmodule

// File: rtl/mem_wb.sv
// mem_wb: MEM/WB pipeline register with load-wait FSM and CSR writeback fields.
// Build option: MEM_WB_SUBWORD_EN enables sub-word load extension in load_ext.
module mem_wb
  import mem_wb_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_i,
  input  logic                    flush_i,
  input  logic                    ex_w_reg_enable_i,
  input  logic                    mem_w_reg_enable_i,
  input  logic [RegAddrWidth-1:0] w_reg_addr_i,
  input  logic [Xlen-1:0]         ex_w_reg_data_i,
  input  logic [Xlen-1:0]         mem_w_reg_data_i,
  input  logic [DataTypeW-1:0]    data_type_i,
  input  logic [1:0]              mem_addr_lo_i,
  input  logic                    r_mem_valid_i,
  input  logic                    ex_w_csr_enable_i,
  input  logic [CsrAddrWidth-1:0] ex_w_csr_addr_i,
  input  logic [Xlen-1:0]         ex_w_csr_data_i,
  output logic                    w_reg_enable_o,
  output logic [RegAddrWidth-1:0] w_reg_addr_o,
  output logic [Xlen-1:0]         w_reg_data_o,
  output logic                    w_csr_enable_o,
  output logic [CsrAddrWidth-1:0] w_csr_addr_o,
  output logic [Xlen-1:0]         w_csr_data_o,
  output logic                    stall_req_o
);

  wb_state_e       state_q;
  logic [Xlen-1:0] load_data;
  logic            addr_nz;

  assign addr_nz = (w_reg_addr_i != '0);

  load_ext u_load_ext (
    .data_type_i (data_type_i),
    .addr_lo_i   (mem_addr_lo_i),
    .raw_i       (mem_w_reg_data_i),
    .data_o      (load_data)
  );

  // Request an upstream stall while a load's read data has not arrived
  always_comb begin
    stall_req_o = 1'b0;
    if (rst && !flush_i) begin
      if (state_q == StWait) stall_req_o = !r_mem_valid_i;
      else                   stall_req_o = mem_w_reg_enable_i && !r_mem_valid_i;
    end
  end

  // Writeback registers and load-wait FSM; flush beats stall, reset beats both
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      w_reg_enable_o <= 1'b0;
      w_reg_addr_o   <= '0;
      w_reg_data_o   <= '0;
      w_csr_enable_o <= 1'b0;
      w_csr_addr_o   <= '0;
      w_csr_data_o   <= '0;
    end else if (flush_i) begin
      state_q        <= StIdle;
      w_reg_enable_o <= 1'b0;
      w_reg_addr_o   <= '0;
      w_reg_data_o   <= '0;
      w_csr_enable_o <= 1'b0;
      w_csr_addr_o   <= '0;
      w_csr_data_o   <= '0;
    end else if (!stall_i) begin
      w_reg_addr_o <= w_reg_addr_i;
      w_csr_addr_o <= ex_w_csr_addr_i;
      w_csr_data_o <= ex_w_csr_data_i;
      if (state_q == StWait || mem_w_reg_enable_i) begin
        if (r_mem_valid_i) begin
          state_q        <= StIdle;
          w_reg_enable_o <= addr_nz;
          w_reg_data_o   <= load_data;
          w_csr_enable_o <= ex_w_csr_enable_i;
        end else begin
          // Data not back yet: emit a bubble and keep waiting
          state_q        <= StWait;
          w_reg_enable_o <= 1'b0;
          w_reg_data_o   <= '0;
          w_csr_enable_o <= 1'b0;
        end
      end else begin
        state_q        <= StIdle;
        w_reg_enable_o <= ex_w_reg_enable_i && addr_nz;
        w_reg_data_o   <= ex_w_reg_data_i;
        w_csr_enable_o <= ex_w_csr_enable_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb.sv
// Directed bench for mem_wb: single-cycle vector table plus load-wait, flush and reset
// sequences. Expected sub-word values depend on MEM_WB_SUBWORD_EN.
module tb_mem_wb;

`ifdef MEM_WB_SUBWORD_EN
  localparam bit Subword = 1'b1;
`else
  localparam bit Subword = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, flush_i, ex_w_reg_enable_i, mem_w_reg_enable_i;
  logic [4:0]  w_reg_addr_i;
  logic [31:0] ex_w_reg_data_i, mem_w_reg_data_i;
  logic [2:0]  data_type_i;
  logic [1:0]  mem_addr_lo_i;
  logic        r_mem_valid_i, ex_w_csr_enable_i;
  logic [11:0] ex_w_csr_addr_i;
  logic [31:0] ex_w_csr_data_i;
  logic        w_reg_enable_o, w_csr_enable_o, stall_req_o;
  logic [4:0]  w_reg_addr_o;
  logic [31:0] w_reg_data_o, w_csr_data_o;
  logic [11:0] w_csr_addr_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb dut (
    .clk                (clk),
    .rst                (rst),
    .stall_i            (stall_i),
    .flush_i            (flush_i),
    .ex_w_reg_enable_i  (ex_w_reg_enable_i),
    .mem_w_reg_enable_i (mem_w_reg_enable_i),
    .w_reg_addr_i       (w_reg_addr_i),
    .ex_w_reg_data_i    (ex_w_reg_data_i),
    .mem_w_reg_data_i   (mem_w_reg_data_i),
    .data_type_i        (data_type_i),
    .mem_addr_lo_i      (mem_addr_lo_i),
    .r_mem_valid_i      (r_mem_valid_i),
    .ex_w_csr_enable_i  (ex_w_csr_enable_i),
    .ex_w_csr_addr_i    (ex_w_csr_addr_i),
    .ex_w_csr_data_i    (ex_w_csr_data_i),
    .w_reg_enable_o     (w_reg_enable_o),
    .w_reg_addr_o       (w_reg_addr_o),
    .w_reg_data_o       (w_reg_data_o),
    .w_csr_enable_o     (w_csr_enable_o),
    .w_csr_addr_o       (w_csr_addr_o),
    .w_csr_data_o       (w_csr_data_o),
    .stall_req_o        (stall_req_o)
  );

  typedef struct {
    logic        ex_en;
    logic        mem_en;
    logic [4:0]  addr;
    logic [31:0] ex_data;
    logic [31:0] mem_data;
    logic [2:0]  dtype;
    logic [1:0]  lo;
    logic        csr_en;
    logic [11:0] csr_addr;
    logic [31:0] csr_data;
    logic        exp_en;
    logic [31:0] exp_data;
    logic        exp_csr_en;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    stall_i = 0; flush_i = 0; ex_w_reg_enable_i = 0; mem_w_reg_enable_i = 0;
    w_reg_addr_i = 0; ex_w_reg_data_i = 0; mem_w_reg_data_i = 0; data_type_i = 3'd2;
    mem_addr_lo_i = 0; r_mem_valid_i = 0; ex_w_csr_enable_i = 0; ex_w_csr_addr_i = 0;
    ex_w_csr_data_i = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_write(input logic [4:0] a, input logic [31:0] d);
    idle_inputs();
    ex_w_reg_enable_i = 1; w_reg_addr_i = a; ex_w_reg_data_i = d;
    tick();
  endtask

  initial begin
    //          ex mem addr  ex_data        mem_data       type  lo  csr addr     csr_data
    //          exp_en exp_data                                         exp_csr
    vecs[0]  = '{0, 1, 5'd5, 32'h0,         32'hDEADBEEF, 3'd2, 2'd0, 0, 12'h0, 32'h0,
                 1, 32'hDEADBEEF, 0};
    vecs[1]  = '{0, 1, 5'd6, 32'h0,         32'h80112233, 3'd0, 2'd3, 0, 12'h0, 32'h0,
                 1, Subword ? 32'hFFFFFF80 : 32'h80112233, 0};
    vecs[2]  = '{0, 1, 5'd6, 32'h0,         32'h80112233, 3'd4, 2'd3, 0, 12'h0, 32'h0,
                 1, Subword ? 32'h00000080 : 32'h80112233, 0};
    vecs[3]  = '{0, 1, 5'd7, 32'h0,         32'h80112233, 3'd5, 2'd2, 0, 12'h0, 32'h0,
                 1, Subword ? 32'h00008011 : 32'h80112233, 0};
    vecs[4]  = '{0, 1, 5'd8, 32'h0,         32'h80118233, 3'd1, 2'd0, 0, 12'h0, 32'h0,
                 1, Subword ? 32'hFFFF8233 : 32'h80118233, 0};
    vecs[5]  = '{0, 1, 5'd9, 32'h0,         32'h80112233, 3'd0, 2'd1, 0, 12'h0, 32'h0,
                 1, Subword ? 32'h00000022 : 32'h80112233, 0};
    vecs[6]  = '{0, 1, 5'd10, 32'h0,        32'h12345678, 3'd3, 2'd1, 0, 12'h0, 32'h0,
                 1, 32'h12345678, 0};
    vecs[7]  = '{1, 0, 5'd0, 32'h5,         32'h0,        3'd2, 2'd0, 0, 12'h0, 32'h0,
                 0, 32'h0, 0};
    vecs[8]  = '{1, 0, 5'd7, 32'h5,         32'h0,        3'd2, 2'd0, 0, 12'h0, 32'h0,
                 1, 32'h5, 0};
    vecs[9]  = '{1, 1, 5'd11, 32'h1111,     32'h2222,     3'd2, 2'd0, 0, 12'h0, 32'h0,
                 1, 32'h2222, 0};
    vecs[10] = '{0, 0, 5'd0, 32'h0,         32'h0,        3'd2, 2'd0, 1, 12'h300, 32'h8,
                 0, 32'h0, 1};
    vecs[11] = '{0, 0, 5'd12, 32'hAB,       32'h0,        3'd2, 2'd0, 0, 12'h0, 32'h0,
                 0, 32'h0, 0};

    // Reset with a waiting load presented: no stall request, outputs clear
    idle_inputs();
    rst = 0;
    mem_w_reg_enable_i = 1; w_reg_addr_i = 5'd5;
    #2;
    chk("rst_stall_req", 32'(stall_req_o), 32'd0);
    tick();
    chk("rst_reg_en", 32'(w_reg_enable_o), 32'd0);
    chk("rst_reg_data", w_reg_data_o, 32'd0);
    chk("rst_csr_en", 32'(w_csr_enable_o), 32'd0);
    chk("rst_csr_addr", 32'(w_csr_addr_o), 32'd0);
    idle_inputs();
    rst = 1;
    tick();

    // Single-cycle vectors: valid read data or non-load, result one edge later
    for (int i = 0; i < 12; i++) begin
      idle_inputs();
      ex_w_reg_enable_i  = vecs[i].ex_en;
      mem_w_reg_enable_i = vecs[i].mem_en;
      w_reg_addr_i       = vecs[i].addr;
      ex_w_reg_data_i    = vecs[i].ex_data;
      mem_w_reg_data_i   = vecs[i].mem_data;
      data_type_i        = vecs[i].dtype;
      mem_addr_lo_i      = vecs[i].lo;
      r_mem_valid_i      = 1;
      ex_w_csr_enable_i  = vecs[i].csr_en;
      ex_w_csr_addr_i    = vecs[i].csr_addr;
      ex_w_csr_data_i    = vecs[i].csr_data;
      #1;
      chk($sformatf("vec%0d_stall_req", i), 32'(stall_req_o), 32'd0);
      tick();
      chk($sformatf("vec%0d_reg_en", i), 32'(w_reg_enable_o), 32'(vecs[i].exp_en));
      if (vecs[i].exp_en) begin
        chk($sformatf("vec%0d_reg_addr", i), 32'(w_reg_addr_o), 32'(vecs[i].addr));
        chk($sformatf("vec%0d_reg_data", i), w_reg_data_o, vecs[i].exp_data);
      end
      chk($sformatf("vec%0d_csr_en", i), 32'(w_csr_enable_o), 32'(vecs[i].exp_csr_en));
      if (vecs[i].exp_csr_en) begin
        chk($sformatf("vec%0d_csr_addr", i), 32'(w_csr_addr_o), 32'(vecs[i].csr_addr));
        chk($sformatf("vec%0d_csr_data", i), w_csr_data_o, vecs[i].csr_data);
      end
    end

    // Stall holds outputs
    ex_write(5'd3, 32'h77);
    ex_w_reg_enable_i = 1; w_reg_addr_i = 5'd4; ex_w_reg_data_i = 32'h99; stall_i = 1;
    tick();
    chk("stall_hold_addr", 32'(w_reg_addr_o), 32'd3);
    chk("stall_hold_data", w_reg_data_o, 32'h77);

    // Load with valid low for three cycles, then valid
    idle_inputs();
    mem_w_reg_enable_i = 1; w_reg_addr_i = 5'd9; mem_w_reg_data_i = 32'hAABBCCDD;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("wait%0d_stall_req", k), 32'(stall_req_o), 32'd1);
      tick();
      chk($sformatf("wait%0d_bubble", k), 32'(w_reg_enable_o), 32'd0);
    end
    r_mem_valid_i = 1;
    #1;
    chk("wait_valid_stall_req", 32'(stall_req_o), 32'd0);
    tick();
    chk("wait_done_en", 32'(w_reg_enable_o), 32'd1);
    chk("wait_done_addr", 32'(w_reg_addr_o), 32'd9);
    chk("wait_done_data", w_reg_data_o, 32'hAABBCCDD);
    idle_inputs();
    #1;
    chk("wait_done_idle", 32'(stall_req_o), 32'd0);

    // Flush together with stall while in WAIT
    mem_w_reg_enable_i = 1; w_reg_addr_i = 5'd9;
    tick();
    chk("flush_pre_stall_req", 32'(stall_req_o), 32'd1);
    flush_i = 1; stall_i = 1;
    #1;
    chk("flush_stall_req", 32'(stall_req_o), 32'd0);
    tick();
    chk("flush_bubble", 32'(w_reg_enable_o), 32'd0);
    idle_inputs();
    #1;
    chk("flush_back_idle", 32'(stall_req_o), 32'd0);
    ex_write(5'd3, 32'h55);
    flush_i = 1; stall_i = 1;
    tick();
    chk("flush_over_stall_en", 32'(w_reg_enable_o), 32'd0);

    // Reset clears outputs immediately
    ex_write(5'd3, 32'h77);
    ex_w_csr_enable_i = 1; ex_w_csr_addr_i = 12'h300; ex_w_csr_data_i = 32'h8;
    tick();
    chk("pre_rst_csr_en", 32'(w_csr_enable_o), 32'd1);
    #2 rst = 0;
    #1;
    chk("rst_async_reg_en", 32'(w_reg_enable_o), 32'd0);
    chk("rst_async_reg_data", w_reg_data_o, 32'd0);
    chk("rst_async_csr_en", 32'(w_csr_enable_o), 32'd0);
    tick();
    rst = 1;

    // Reset in WAIT abandons the load
    idle_inputs();
    mem_w_reg_enable_i = 1; w_reg_addr_i = 5'd9; mem_w_reg_data_i = 32'h13572468;
    tick();
    chk("rstwait_stall_req", 32'(stall_req_o), 32'd1);
    #2 rst = 0;
    #1;
    chk("rstwait_stall_req_low", 32'(stall_req_o), 32'd0);
    chk("rstwait_reg_en", 32'(w_reg_enable_o), 32'd0);
    tick();
    idle_inputs();
    rst = 1;
    w_reg_addr_i = 5'd9; mem_w_reg_data_i = 32'h13572468; r_mem_valid_i = 1;
    tick();
    chk("rstwait_no_writeback", 32'(w_reg_enable_o), 32'd0);
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
